core_clk_en_sequencer: RTL and testbench

//  Drives the six clock-enable inputs of core_clk_gating_control from phase requests issued by the core controller.
//  - Maps each phase to a domain mask.
//  - Opens the needed clocks WAKE_CYCLES before granting the phase.
//  - Keeps each domain clock on IDLE_HOLD cycles after its last use.

---
 rtl/core_clk_pkg.sv | 41 ++++
 rtl/clk_en_hold_timer.sv | 43 ++++
 rtl/core_clk_en_sequencer.sv | 124 ++++++++++++
 tb/tb_core_clk_en_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_clk_pkg.sv
// Shared types for the core clock-enable sequencer:
// phase codes, domain indices, phase-to-mask map, FSM states.
package core_clk_pkg;

  localparam int NDOM = 6;

  localparam logic [2:0] PH_WLOAD = 3'd1;
  localparam logic [2:0] PH_EXEC  = 3'd2;
  localparam logic [2:0] PH_DRAIN = 3'd3;
  localparam logic [2:0] PH_SFU   = 3'd4;

  localparam int DOM_WEIGHTS = 5;
  localparam int DOM_PSUM    = 4;
  localparam int DOM_MAC     = 3;
  localparam int DOM_L0      = 2;
  localparam int DOM_OFIFO   = 1;
  localparam int DOM_SFU     = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAKE,
    ST_RUN
  } state_e;

  // Bit order {W,P,M,L,O,S}; an all-zero result marks an illegal code.
  function automatic logic [NDOM-1:0] PHASE_MASK(
    input logic [2:0] ph
  );
    logic [NDOM-1:0] m;
    m = '0;
    case (ph)
      PH_WLOAD: m = 6'b101100;
      PH_EXEC:  m = 6'b011110;
      PH_DRAIN: m = 6'b010011;
      PH_SFU:   m = 6'b010001;
      default:  m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/clk_en_hold_timer.sv
// Per-domain enable flop with an idle hold-off counter.
// Ports: clk, reset (async low), keep, want, force_on, en_out.
module clk_en_hold_timer #(
  parameter int IDLE_HOLD = 4
) (
  input  logic clk,
  input  logic reset,
  // keep: domain in use this cycle (reloads hold)
  input  logic keep,
  // want: domain needed next cycle
  input  logic want,
  input  logic force_on,
  output logic en_out
);

  localparam int HOLD_W =
    (IDLE_HOLD > 0) ? $clog2(IDLE_HOLD + 1) : 1;

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              en_q, en_d;

  always_comb begin
    hold_d = hold_q;
    if (keep)
      hold_d = HOLD_W'(IDLE_HOLD);
    else if (hold_q != '0)
      hold_d = hold_q - HOLD_W'(1);
    en_d = force_on | want | (hold_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
      en_q   <= 1'b0;
    end else begin
      hold_q <= hold_d;
      en_q   <= en_d;
    end
  end

  assign en_out = en_q;

endmodule

// File: rtl/core_clk_en_sequencer.sv
// Phase-request driven clock-enable sequencer: wake, run, idle hold.
// In: req_valid/req_phase/phase_end/busy/force_on; out: six enables + handshake.
module core_clk_en_sequencer
  import core_clk_pkg::*;
#(
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_HOLD   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [2:0] req_phase,
  output logic       req_ready,
  input  logic       phase_end,
  input  logic [5:0] busy,
  input  logic       force_on,
  output logic       phase_go,
  output logic       phase_done,
  output logic       phase_err,
  output logic       weights_sram_clk_en,
  output logic       psum_sram_clk_en,
  output logic       mac_array_clk_en,
  output logic       l0_clk_en,
  output logic       ofifo_clk_en,
  output logic       sfu_clk_en,
  output logic       all_gated
);

  localparam int WK_W =
    (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [NDOM-1:0]   mask_q, mask_d;
  logic [WK_W-1:0]   wake_q, wake_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [NDOM-1:0]   en_q;
  logic [NDOM-1:0]   req_mask;

  assign req_ready = reset & (state_q == ST_IDLE);
  assign phase_go  = (state_q == ST_RUN);
  assign phase_done = done_q;
  assign phase_err  = err_q;
  assign all_gated =
    (state_q == ST_IDLE) & (en_q == '0);

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    wake_d   = wake_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    req_mask = PHASE_MASK(req_phase);
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          if (req_mask == '0) begin
            err_d = 1'b1;
          end else begin
            mask_d = req_mask;
            // Clocks already open: no wake delay.
            if ((req_mask & ~en_q) == '0) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_WAKE;
              wake_d  = WK_W'(WAKE_CYCLES - 1);
            end
          end
        end
      end
      ST_WAKE: begin
        if (wake_q == '0)
          state_d = ST_RUN;
        else
          wake_d = wake_q - WK_W'(1);
      end
      ST_RUN: begin
        if (phase_end) begin
          state_d = ST_IDLE;
          mask_d  = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      wake_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      wake_q  <= wake_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  for (genvar i = 0; i < NDOM; i++) begin : g_dom
    clk_en_hold_timer #(
      .IDLE_HOLD(IDLE_HOLD)
    ) u_tmr (
      .clk     (clk),
      .reset   (reset),
      .keep    (mask_q[i] | busy[i]),
      .want    (mask_d[i] | busy[i]),
      .force_on(force_on),
      .en_out  (en_q[i])
    );
  end

  assign weights_sram_clk_en = en_q[DOM_WEIGHTS];
  assign psum_sram_clk_en    = en_q[DOM_PSUM];
  assign mac_array_clk_en    = en_q[DOM_MAC];
  assign l0_clk_en           = en_q[DOM_L0];
  assign ofifo_clk_en        = en_q[DOM_OFIFO];
  assign sfu_clk_en          = en_q[DOM_SFU];

endmodule

// File: tb/tb_core_clk_en_sequencer.sv
// Bench for core_clk_en_sequencer: vector table, corner
// sequences and random traffic against a timestamp model.
module tb_core_clk_en_sequencer;

  localparam int WAKE = 2;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_phase = 3'd0;
  logic       phase_end = 1'b0;
  logic [5:0] busy = 6'd0;
  logic       force_on = 1'b0;
  logic       req_ready, phase_go, phase_done, phase_err;
  logic       all_gated;
  logic       w_en, p_en, m_en, l_en, o_en, s_en;
  logic [5:0] en;

  assign en = {w_en, p_en, m_en, l_en, o_en, s_en};

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  core_clk_en_sequencer #(
    .WAKE_CYCLES(WAKE),
    .IDLE_HOLD  (HOLD)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_phase          (req_phase),
    .req_ready          (req_ready),
    .phase_end          (phase_end),
    .busy               (busy),
    .force_on           (force_on),
    .phase_go           (phase_go),
    .phase_done         (phase_done),
    .phase_err          (phase_err),
    .weights_sram_clk_en(w_en),
    .psum_sram_clk_en   (p_en),
    .mac_array_clk_en   (m_en),
    .l0_clk_en          (l_en),
    .ofifo_clk_en       (o_en),
    .sfu_clk_en         (s_en),
    .all_gated          (all_gated)
  );

  // Reference model: phase state plus, per domain, the
  // edge index of its last use; an enable is held while
  // fewer than HOLD edges have passed since that use.
  logic [5:0] MASKS [8] = '{6'b000000, 6'b101100,
    6'b011110, 6'b010011, 6'b010001,
    6'b000000, 6'b000000, 6'b000000};
  int         r_st = 0;
  int         r_n = 0;
  int         r_go_at = 0;
  int         r_last [6] = '{default: -1000};
  logic [5:0] r_mask = 6'd0;
  logic [5:0] r_nm = 6'd0;
  logic [5:0] r_en = 6'd0;
  logic       r_done = 1'b0;
  logic       r_err = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_st = 0; r_mask = 0; r_en = 0;
      r_done = 0; r_err = 0; r_n = 0;
      for (int i = 0; i < 6; i++) r_last[i] = -1000;
    end else begin
      r_n++;
      r_nm = r_mask;
      r_done = 0;
      r_err = 0;
      for (int i = 0; i < 6; i++)
        if (r_mask[i] | busy[i]) r_last[i] = r_n;
      if (r_st == 0) begin
        if (req_valid) begin
          if (MASKS[req_phase] == 0) begin
            r_err = 1;
          end else begin
            r_nm = MASKS[req_phase];
            if ((r_nm & ~r_en) == 0) begin
              r_st = 2;
            end else begin
              r_st = 1;
              r_go_at = r_n + WAKE;
            end
          end
        end
      end else if (r_st == 1) begin
        if (r_n == r_go_at) r_st = 2;
      end else begin
        if (phase_end) begin
          r_st = 0; r_nm = 0; r_done = 1;
        end
      end
      r_mask = r_nm;
      for (int i = 0; i < 6; i++)
        r_en[i] = force_on | r_nm[i] | busy[i] |
                  ((r_n - r_last[i]) < HOLD);
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all();
    logic [10:0] act, exp;
    act = {req_ready, phase_go, phase_done, phase_err,
           all_gated, en};
    exp = {reset && (r_st == 0), r_st == 2, r_done, r_err,
           (r_st == 0) && (r_en == 0), r_en};
    chk("model", 32'(act), 32'(exp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drain();
    repeat (HOLD + 2) step();
  endtask

  task automatic req(input logic [2:0] ph);
    req_valid = 1'b1;
    req_phase = ph;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_go();
    int k;
    k = 0;
    while (!phase_go && k < 8) begin
      step();
      k++;
    end
    chk("go_timeout", 32'(phase_go), 32'(1));
  endtask

  task automatic end_phase();
    phase_end = 1'b1;
    step();
    phase_end = 1'b0;
  endtask

  typedef struct {
    logic [2:0] code;
    logic [5:0] en_exp;
    logic       err_exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{3'd0, 6'b000000, 1'b1};
    vecs[1] = '{3'd1, 6'b101100, 1'b0};
    vecs[2] = '{3'd2, 6'b011110, 1'b0};
    vecs[3] = '{3'd3, 6'b010011, 1'b0};
    vecs[4] = '{3'd4, 6'b010001, 1'b0};
    vecs[5] = '{3'd5, 6'b000000, 1'b1};
    vecs[6] = '{3'd6, 6'b000000, 1'b1};
    vecs[7] = '{3'd7, 6'b000000, 1'b1};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", 32'(en), 32'(0));
    chk("rst_ready", 32'(req_ready), 32'(0));
    chk("rst_go", 32'(phase_go), 32'(0));
    chk("rst_done", 32'(phase_done), 32'(0));
    chk("rst_err", 32'(phase_err), 32'(0));
    reset = 1'b1;
    step();
    chk("idle_ready", 32'(req_ready), 32'(1));
    chk("idle_gated", 32'(all_gated), 32'(1));

    // Table: every code from a fully gated idle state.
    foreach (vecs[v]) begin
      drain();
      chk("tbl_gated", 32'(all_gated), 32'(1));
      req(vecs[v].code);
      chk("tbl_en", 32'(en), 32'(vecs[v].en_exp));
      chk("tbl_err", 32'(phase_err), 32'(vecs[v].err_exp));
      if (!vecs[v].err_exp) begin
        wait_go();
        end_phase();
        chk("tbl_done", 32'(phase_done), 32'(1));
      end
    end
    drain();

    // Cold EXEC: enables at t, phase_go at t+2.
    req(3'd2);
    chk("cold_en", 32'(en), 32'(6'b011110));
    chk("cold_go_t", 32'(phase_go), 32'(0));
    chk("cold_rdy", 32'(req_ready), 32'(0));
    step();
    chk("cold_go_t1", 32'(phase_go), 32'(0));
    step();
    chk("cold_go_t2", 32'(phase_go), 32'(1));
    chk("cold_rdy2", 32'(req_ready), 32'(0));

    // Hold after phase_end.
    end_phase();
    chk("hold_done", 32'(phase_done), 32'(1));
    chk("hold_en_t", 32'(en), 32'(6'b011110));
    repeat (3) step();
    chk("hold_done_off", 32'(phase_done), 32'(0));
    chk("hold_en_t3", 32'(en), 32'(6'b011110));
    step();
    chk("hold_en_t4", 32'(en), 32'(0));
    chk("hold_gated", 32'(all_gated), 32'(1));
    drain();

    // Warm reuse: EXEC, then DRAIN two cycles after end.
    req(3'd2);
    wait_go();
    end_phase();
    step();
    req(3'd3);
    chk("warm_en", 32'(en), 32'(6'b011111));
    chk("warm_go_t", 32'(phase_go), 32'(0));
    step();
    chk("warm_go_t1", 32'(phase_go), 32'(0));
    step();
    chk("warm_go_t2", 32'(phase_go), 32'(1));
    end_phase();
    req(3'd4);
    chk("warm_sfu_go", 32'(phase_go), 32'(1));
    chk("warm_sfu_en", 32'(en), 32'(6'b010011));
    end_phase();
    drain();

    // Illegal code 6.
    req(3'd6);
    chk("ill_err", 32'(phase_err), 32'(1));
    chk("ill_en", 32'(en), 32'(0));
    chk("ill_rdy", 32'(req_ready), 32'(1));
    step();
    chk("ill_err_off", 32'(phase_err), 32'(0));
    drain();

    // busy[3] for three cycles while idle.
    busy = 6'b001000;
    step();
    chk("busy_rise", 32'(en), 32'(6'b001000));
    repeat (2) step();
    busy = 6'b000000;
    repeat (3) step();
    chk("busy_hold", 32'(m_en), 32'(1));
    step();
    chk("busy_fall", 32'(en), 32'(0));
    drain();

    // force_on: all enables, WLOAD skips wake.
    force_on = 1'b1;
    step();
    chk("force_en", 32'(en), 32'(6'b111111));
    req(3'd1);
    chk("force_go", 32'(phase_go), 32'(1));
    end_phase();
    force_on = 1'b0;
    drain();

    // Reset asserted mid-RUN.
    req(3'd2);
    wait_go();
    #2;
    reset = 1'b0;
    #1;
    chk("mrst_en", 32'(en), 32'(0));
    chk("mrst_go", 32'(phase_go), 32'(0));
    chk("mrst_rdy", 32'(req_ready), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    chk("mrst_idle", 32'(req_ready), 32'(1));
    chk("mrst_gated", 32'(all_gated), 32'(1));

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom_range(0, 3) == 0);
      req_phase = 3'($urandom_range(0, 7));
      phase_end = ($urandom_range(0, 3) == 0);
      force_on  = ($urandom_range(0, 63) == 0);
      for (int b = 0; b < 6; b++)
        busy[b] = ($urandom_range(0, 15) == 0);
      step();
    end
    req_valid = 1'b0;
    phase_end = 1'b1;
    force_on  = 1'b0;
    busy      = 6'd0;
    step();
    phase_end = 1'b0;
    drain();
    chk("final_gated", 32'(all_gated), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
